// File: rtl/eu_sequencer.sv
// Queues EU commands and runs each through parameter fetch, execute and response, one at a time.
// A per-EU tag cache skips the fetch when the EU already holds parameters from the same address.
module eu_sequencer #(
  parameter int NUM_EU     = 4,
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(NUM_EU)-1:0] cmd_eu,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic                      cmd_force,
  input  logic                      flush,
  output logic [NUM_EU-1:0]         eu_fetch,
  output logic [ADDR_W-1:0]         eu_fetch_addr,
  output logic [NUM_EU-1:0]         eu_exec,
  input  logic [NUM_EU-1:0]         eu_fetch_done,
  input  logic [NUM_EU-1:0]         eu_exec_done,
  output logic                      rsp_valid,
  output logic [$clog2(NUM_EU)-1:0] rsp_eu,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int EW    = $clog2(NUM_EU);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;
  localparam int ENT_W = EW + ADDR_W + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] FWAIT = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] XWAIT = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]                          state_q, state_d;
  logic [FIFO_DEPTH-1:0][ENT_W-1:0]    mem_q, mem_d;
  logic [PW-1:0]                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                       count_q, count_d;
  logic [EW-1:0]                       cur_eu_q, cur_eu_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [TW-1:0]                       timer_q, timer_d;
  logic                                err_q, err_d;
  logic [EW-1:0]                       rsp_eu_q, rsp_eu_d;
  logic [NUM_EU-1:0]                   valid_q, valid_d;
  logic [NUM_EU-1:0][ADDR_W-1:0]       tag_q, tag_d;

  logic              full, empty, push, pop;
  logic [ENT_W-1:0]  head;
  logic [EW-1:0]     head_eu;
  logic [ADDR_W-1:0] head_addr;
  logic              head_force, head_legal, hit;
  logic              fdone, xdone, timeout;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = cmd_valid && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign head       = mem_q[rd_ptr_q];
  assign head_eu    = head[ENT_W-1 -: EW];
  assign head_addr  = head[ADDR_W:1];
  assign head_force = head[0];
  assign head_legal = (32'(head_eu) < 32'(NUM_EU));
  // A flush in the pop cycle must turn a would-be hit into a miss.
  assign hit        = head_legal && valid_q[head_eu] && !flush &&
                      (tag_q[head_eu] == head_addr) && !head_force;
  assign fdone      = eu_fetch_done[cur_eu_q];
  assign xdone      = eu_exec_done[cur_eu_q];
  assign timeout    = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_eu, cmd_addr, cmd_force};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cur_eu_d = cur_eu_q;
    addr_d   = addr_q;
    timer_d  = timer_q;
    err_d    = err_q;
    rsp_eu_d = rsp_eu_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          cur_eu_d = head_eu;
          addr_d   = head_addr;
          err_d    = 1'b0;
          if (!head_legal) begin
            err_d    = 1'b1;
            rsp_eu_d = head_eu;
            state_d  = RESP;
          end else if (hit) begin
            state_d = EXEC;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        timer_d = '0;
        state_d = FWAIT;
      end
      FWAIT: begin
        timer_d = timer_q + TW'(1);
        if (fdone) begin
          valid_d[cur_eu_q] = 1'b1;
          tag_d[cur_eu_q]   = addr_q;
          state_d           = EXEC;
        end else if (timeout) begin
          err_d             = 1'b1;
          valid_d[cur_eu_q] = 1'b0;
          rsp_eu_d          = cur_eu_q;
          state_d           = RESP;
        end
      end
      EXEC: begin
        timer_d = '0;
        state_d = XWAIT;
      end
      XWAIT: begin
        timer_d = timer_q + TW'(1);
        if (xdone) begin
          rsp_eu_d = cur_eu_q;
          state_d  = RESP;
        end else if (timeout) begin
          err_d             = 1'b1;
          valid_d[cur_eu_q] = 1'b0;
          rsp_eu_d          = cur_eu_q;
          state_d           = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_eu_q <= '0;
      addr_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      rsp_eu_q <= '0;
      valid_q  <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_eu_q <= cur_eu_d;
      addr_q   <= addr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      rsp_eu_q <= rsp_eu_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
    end
  end

  assign cmd_ready     = !full;
  assign eu_fetch      = (state_q == FETCH) ? (NUM_EU'(1) << cur_eu_q) : '0;
  assign eu_exec       = (state_q == EXEC)  ? (NUM_EU'(1) << cur_eu_q) : '0;
  assign eu_fetch_addr = addr_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_err       = rsp_valid && err_q;
  assign rsp_eu        = rsp_eu_q;
  assign busy          = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_eu_sequencer.sv
// Directed bench for eu_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_eu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_eu = '0;
  logic [23:0] cmd_addr = '0;
  logic        cmd_force = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  eu_fetch;
  logic [23:0] eu_fetch_addr;
  logic [3:0]  eu_exec;
  logic [3:0]  eu_fetch_done = '0;
  logic [3:0]  eu_exec_done = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_eu;
  logic        rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  eu_sequencer #(.NUM_EU(4), .ADDR_W(24), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_eu(cmd_eu), .cmd_addr(cmd_addr), .cmd_force(cmd_force), .flush(flush),
    .eu_fetch(eu_fetch), .eu_fetch_addr(eu_fetch_addr), .eu_exec(eu_exec),
    .eu_fetch_done(eu_fetch_done), .eu_exec_done(eu_exec_done),
    .rsp_valid(rsp_valid), .rsp_eu(rsp_eu), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] eu, input logic [23:0] a, input logic f);
    cmd_valid = 1'b1; cmd_eu = eu; cmd_addr = a; cmd_force = f;
    tick();
    cmd_valid = 1'b0; cmd_force = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (eu_fetch == 4'b0 && n < 40) begin tick(); n++; end
    ok = (eu_fetch != 4'b0);
  endtask

  // Serves one queued command: answers fetch after fdly cycles and exec after xdly cycles.
  task automatic do_cmd(input int eu, input int fdly, input int xdly,
                        output bit ok, output bit fseen, output int lead,
                        output logic [3:0] f_oh, output logic [23:0] f_addr,
                        output logic [1:0] r_eu, output logic r_err);
    int n = 0;
    ok = 1'b0; fseen = 1'b0; lead = -1; f_oh = '0; f_addr = '0; r_eu = '0; r_err = 1'b0;
    while (eu_fetch == 4'b0 && eu_exec == 4'b0 && n < 60) begin tick(); n++; end
    if (n >= 60) return;
    lead = n;
    if (eu_fetch != 4'b0) begin
      fseen = 1'b1; f_oh = eu_fetch; f_addr = eu_fetch_addr;
      repeat (fdly) tick();
      eu_fetch_done[eu] = 1'b1; tick(); eu_fetch_done = '0;
      n = 0;
      while (eu_exec == 4'b0 && n < 60) begin tick(); n++; end
      if (n >= 60) return;
    end
    repeat (xdly) tick();
    eu_exec_done[eu] = 1'b1; tick(); eu_exec_done = '0;
    n = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    if (n >= 60) return;
    r_eu = rsp_eu; r_err = rsp_err; ok = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (eu_fetch !== 4'b0 || eu_exec !== 4'b0) begin n_bad++; $display("FAIL reset_pulses: fetch=%b exec=%b want 0000/0000", eu_fetch, eu_exec); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_eu !== 2'd0) begin n_bad++; $display("FAIL reset_rsp: v=%b err=%b eu=%0d want 0/0/0", rsp_valid, rsp_err, rsp_eu); end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_busy_ready: busy=%b ready=%b want 0/1", busy, cmd_ready); end
    n_cmp++; if (eu_fetch_addr !== 24'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 000000", eu_fetch_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_miss();
    push(2'd1, 24'h000100, 1'b0);
    n_cmp++; if (eu_fetch !== 4'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL miss_t1: fetch=%b busy=%b want 0000/1", eu_fetch, busy); end
    tick();
    n_cmp++; if (eu_fetch !== 4'b0010) begin n_bad++; $display("FAIL miss_fetch: got %b want 0010", eu_fetch); end
    n_cmp++; if (eu_fetch_addr !== 24'h000100) begin n_bad++; $display("FAIL miss_addr: got %h want 000100", eu_fetch_addr); end
    repeat (5) tick();
    eu_fetch_done = 4'b0010; tick(); eu_fetch_done = '0;
    n_cmp++; if (eu_exec !== 4'b0010) begin n_bad++; $display("FAIL miss_exec: got %b want 0010", eu_exec); end
    repeat (3) tick();
    eu_exec_done = 4'b0010; tick(); eu_exec_done = '0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_eu !== 2'd1 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL miss_rsp: v=%b eu=%0d err=%b want 1/1/0", rsp_valid, rsp_eu, rsp_err); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_eu !== 2'd1) begin n_bad++; $display("FAIL miss_after: v=%b busy=%b eu=%0d want 0/0/1", rsp_valid, busy, rsp_eu); end
  endtask

  task automatic test_hit_and_force();
    bit ok, fs; int lead; logic [3:0] foh; logic [23:0] fa; logic [1:0] re; logic rr;
    push(2'd1, 24'h000100, 1'b0);
    do_cmd(1, 1, 1, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b0 || lead != 1) begin n_bad++; $display("FAIL hit_exec: ok=%b fetch=%b lead=%0d want 1/0/1", ok, fs, lead); end
    n_cmp++; if (re !== 2'd1 || rr !== 1'b0) begin n_bad++; $display("FAIL hit_rsp: eu=%0d err=%b want 1/0", re, rr); end
    push(2'd1, 24'h000100, 1'b1);
    do_cmd(1, 1, 1, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b1 || foh !== 4'b0010 || lead != 1) begin n_bad++; $display("FAIL force_fetch: ok=%b fetch=%b oh=%b lead=%0d want 1/1/0010/1", ok, fs, foh, lead); end
  endtask

  task automatic test_timeout();
    bit ok, fs; int lead; logic [3:0] foh; logic [23:0] fa; logic [1:0] re; logic rr;
    push(2'd3, 24'h000300, 1'b0);
    wait_fetch(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_fetch_wait: got no eu_fetch want pulse"); end
    tick();
    eu_fetch_done = 4'b1000; tick(); eu_fetch_done = '0;
    n_cmp++; if (eu_exec !== 4'b1000) begin n_bad++; $display("FAIL to_exec: got %b want 1000", eu_exec); end
    repeat (16) tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_early: rsp_valid=%b want 0", rsp_valid); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_eu !== 2'd3) begin n_bad++; $display("FAIL to_rsp: v=%b err=%b eu=%0d want 1/1/3", rsp_valid, rsp_err, rsp_eu); end
    tick();
    push(2'd3, 24'h000300, 1'b0);
    do_cmd(3, 1, 1, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b1 || rr !== 1'b0) begin n_bad++; $display("FAIL to_refetch: ok=%b fetch=%b err=%b want 1/1/0", ok, fs, rr); end
  endtask

  task automatic test_back_to_back();
    bit ok, fs; int lead; logic [3:0] foh; logic [23:0] fa; logic [1:0] re; logic rr;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, cmd_ready); end
      if (i == 2) begin
        n_cmp++; if (eu_fetch !== 4'b0001) begin n_bad++; $display("FAIL b2b_fetch0: got %b want 0001", eu_fetch); end
      end
      cmd_valid = 1'b1; cmd_eu = 2'(i % 4); cmd_addr = 24'h001000 + 24'(i * 16);
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: ready=%b want 0", cmd_ready); end
    eu_fetch_done = 4'b0001; tick(); eu_fetch_done = '0;
    n_cmp++; if (eu_exec !== 4'b0001) begin n_bad++; $display("FAIL b2b_exec0: got %b want 0001", eu_exec); end
    tick();
    eu_exec_done = 4'b0001; tick(); eu_exec_done = '0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_eu !== 2'd0 || cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp0: v=%b eu=%0d ready=%b want 1/0/0", rsp_valid, rsp_eu, cmd_ready); end
    for (int i = 1; i < 5; i++) begin
      do_cmd(i % 4, 1, 1, ok, fs, lead, foh, fa, re, rr);
      n_cmp++; if (!ok || lead != 2) begin n_bad++; $display("FAIL b2b_lead%0d: ok=%b lead=%0d want 1/2", i, ok, lead); end
      n_cmp++; if (fs !== 1'b1 || foh !== 4'(1 << (i % 4)) || fa !== 24'h001000 + 24'(i * 16)) begin n_bad++; $display("FAIL b2b_fetch%0d: seen=%b oh=%b addr=%h want 1/%b/%h", i, fs, foh, fa, 4'(1 << (i % 4)), 24'h001000 + 24'(i * 16)); end
      n_cmp++; if (re !== 2'(i % 4) || rr !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp%0d: eu=%0d err=%b want %0d/0", i, re, rr, i % 4); end
      if (i == 1) begin
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_unfull: ready=%b want 1", cmd_ready); end
      end
    end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_flush();
    bit ok, fs; int lead; logic [3:0] foh; logic [23:0] fa; logic [1:0] re; logic rr;
    push(2'd2, 24'h000200, 1'b0);
    wait_fetch(ok);
    n_cmp++; if (!ok || eu_fetch !== 4'b0100) begin n_bad++; $display("FAIL fl_fetch: got %b want 0100", eu_fetch); end
    tick();
    eu_fetch_done = 4'b0100; flush = 1'b1; tick(); eu_fetch_done = '0; flush = 1'b0;
    n_cmp++; if (eu_exec !== 4'b0100) begin n_bad++; $display("FAIL fl_exec: got %b want 0100", eu_exec); end
    tick();
    eu_exec_done = 4'b0100; tick(); eu_exec_done = '0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_eu !== 2'd2) begin n_bad++; $display("FAIL fl_rsp: v=%b eu=%0d want 1/2", rsp_valid, rsp_eu); end
    push(2'd2, 24'h000200, 1'b0);
    do_cmd(2, 1, 1, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b1) begin n_bad++; $display("FAIL fl_refetch: ok=%b fetch=%b want 1/1", ok, fs); end
    push(2'd2, 24'h000200, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    do_cmd(2, 1, 1, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b1 || lead != 0) begin n_bad++; $display("FAIL fl_idle_miss: ok=%b fetch=%b lead=%0d want 1/1/0", ok, fs, lead); end
    push(2'd2, 24'h000200, 1'b0);
    do_cmd(2, 1, 1, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b0) begin n_bad++; $display("FAIL fl_rehit: ok=%b fetch=%b want 1/0", ok, fs); end
  endtask

  task automatic test_spurious_done();
    bit ok;
    push(2'd0, 24'h000040, 1'b0);
    wait_fetch(ok);
    n_cmp++; if (!ok || eu_fetch !== 4'b0001) begin n_bad++; $display("FAIL sp_fetch: got %b want 0001", eu_fetch); end
    tick();
    eu_fetch_done = 4'b1000; eu_exec_done = 4'b1000; tick(); tick();
    eu_fetch_done = '0; eu_exec_done = '0;
    n_cmp++; if (eu_exec !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL sp_fwait: exec=%b v=%b busy=%b want 0000/0/1", eu_exec, rsp_valid, busy); end
    eu_fetch_done = 4'b0001; tick(); eu_fetch_done = '0;
    n_cmp++; if (eu_exec !== 4'b0001) begin n_bad++; $display("FAIL sp_exec: got %b want 0001", eu_exec); end
    tick();
    eu_exec_done = 4'b1000; tick(); eu_exec_done = '0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL sp_xwait: rsp_valid=%b want 0", rsp_valid); end
    eu_exec_done = 4'b0001; tick(); eu_exec_done = '0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_eu !== 2'd0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL sp_rsp: v=%b eu=%0d err=%b want 1/0/0", rsp_valid, rsp_eu, rsp_err); end
  endtask

  task automatic test_reset_mid();
    bit ok, fs; int lead; logic [3:0] foh; logic [23:0] fa; logic [1:0] re; logic rr;
    tick();
    push(2'd1, 24'h000555, 1'b0);
    wait_fetch(ok);
    n_cmp++; if (!ok || eu_fetch_addr !== 24'h000555) begin n_bad++; $display("FAIL rm_fetch: addr=%h want 000555", eu_fetch_addr); end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (eu_fetch !== 4'b0 || eu_exec !== 4'b0 || eu_fetch_addr !== 24'h0) begin n_bad++; $display("FAIL rm_outs: fetch=%b exec=%b addr=%h want 0000/0000/000000", eu_fetch, eu_exec, eu_fetch_addr); end
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rm_busy: busy=%b v=%b ready=%b want 0/0/1", busy, rsp_valid, cmd_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    push(2'd1, 24'h001010, 1'b0);
    do_cmd(1, 2, 2, ok, fs, lead, foh, fa, re, rr);
    n_cmp++; if (!ok || fs !== 1'b1 || fa !== 24'h001010 || lead != 1) begin n_bad++; $display("FAIL rm_resume: ok=%b fetch=%b addr=%h lead=%0d want 1/1/001010/1", ok, fs, fa, lead); end
    n_cmp++; if (re !== 2'd1 || rr !== 1'b0) begin n_bad++; $display("FAIL rm_rsp: eu=%0d err=%b want 1/0", re, rr); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit_and_force();
    test_timeout();
    test_back_to_back();
    test_flush();
    test_spurious_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
